// File: rtl/wb_hazard_ctrl.sv
// wb_hazard_ctrl
//
// Sits between decode and the register-file write port. It tracks which
// registers have a result still in flight, stalls decode on RAW/WAW hazards,
// raises the fetch flush for a taken branch that actually issues, and shares
// the single register-file write port between the ALU and load writeback
// paths. A one-entry hold buffer parks an ALU result that lost the port to a
// load.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_dec_valid             decode holds a valid instruction
//   i_rs1_num/i_rs2_num     source register numbers
//   i_rs1_used/i_rs2_used   instruction reads that source
//   i_rd_num, i_rd_wr       destination register and write flag
//   i_b_taken               branch resolved taken this cycle
//   o_stall                 freeze fetch/decode, bubble downstream
//   o_issue                 decode instruction accepted
//   o_flush_if              kill the instruction in fetch
//   i_alu_wr_valid/num/val  ALU writeback request, o_alu_ready accepts it
//   i_mem_wr_valid/num/val  load writeback request, always accepted
//   o_reg_op                register-file write enable
//   o_w_rd_num, o_w_rd      register-file write number and value

module wb_hazard_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dec_valid,
    input  logic [4:0]  i_rs1_num,
    input  logic [4:0]  i_rs2_num,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    input  logic [4:0]  i_rd_num,
    input  logic        i_rd_wr,
    input  logic        i_b_taken,
    output logic        o_stall,
    output logic        o_issue,
    output logic        o_flush_if,
    input  logic        i_alu_wr_valid,
    input  logic [4:0]  i_alu_rd_num,
    input  logic [31:0] i_alu_rd_val,
    output logic        o_alu_ready,
    input  logic        i_mem_wr_valid,
    input  logic [4:0]  i_mem_rd_num,
    input  logic [31:0] i_mem_rd_val,
    output logic        o_reg_op,
    output logic [4:0]  o_w_rd_num,
    output logic [31:0] o_w_rd
);

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_HELD  = 1'b1
    } wbState_e;

    wbState_e    state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic [4:0]  holdNum_q, holdNum_d;
    logic [31:0] holdVal_q, holdVal_d;

    logic        hazard;
    logic        selValid;
    logic [4:0]  selNum;
    logic [31:0] selVal;

    // Hazard check looks only at the registered scoreboard, so a register
    // committing this very cycle still blocks its readers until next cycle.
    always_comb begin
        hazard      = i_dec_valid & ((i_rs1_used & pend_q[i_rs1_num]) |
                                     (i_rs2_used & pend_q[i_rs2_num]) |
                                     (i_rd_wr    & pend_q[i_rd_num]));
        o_alu_ready = (state_q == WB_EMPTY);
        o_stall     = hazard | (i_alu_wr_valid & ~o_alu_ready);
        o_issue     = i_dec_valid & ~o_stall;
        o_flush_if  = o_issue & i_b_taken;
    end

    // Write-port arbiter: loads always win, then the hold buffer, then a
    // direct ALU write. An ALU request that collides with a load in the empty
    // state is accepted into the hold buffer instead of being refused.
    always_comb begin
        state_d   = state_q;
        holdNum_d = holdNum_q;
        holdVal_d = holdVal_q;
        selValid  = 1'b0;
        selNum    = 5'd0;
        selVal    = 32'd0;
        case (state_q)
            WB_EMPTY: begin
                if (i_mem_wr_valid) begin
                    selValid = 1'b1;
                    selNum   = i_mem_rd_num;
                    selVal   = i_mem_rd_val;
                    if (i_alu_wr_valid) begin
                        holdNum_d = i_alu_rd_num;
                        holdVal_d = i_alu_rd_val;
                        state_d   = WB_HELD;
                    end
                end else if (i_alu_wr_valid) begin
                    selValid = 1'b1;
                    selNum   = i_alu_rd_num;
                    selVal   = i_alu_rd_val;
                end
            end
            WB_HELD: begin
                selValid = 1'b1;
                if (i_mem_wr_valid) begin
                    selNum = i_mem_rd_num;
                    selVal = i_mem_rd_val;
                end else begin
                    selNum  = holdNum_q;
                    selVal  = holdVal_q;
                    state_d = WB_EMPTY;
                end
            end
            default: state_d = WB_EMPTY;
        endcase
    end

    // Writes to x0 are consumed by the arbiter but never reach the register file.
    always_comb begin
        o_reg_op   = selValid & (selNum != 5'd0);
        o_w_rd_num = selNum;
        o_w_rd     = selVal;
    end

    // Scoreboard: clear on commit first, then set on issue so that a
    // same-register set/clear in one cycle leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        if (o_reg_op) begin
            pend_d[o_w_rd_num] = 1'b0;
        end
        if (o_issue && i_rd_wr && (i_rd_num != 5'd0)) begin
            pend_d[i_rd_num] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // State registers; reset drops all pending bits and any held ALU result.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= WB_EMPTY;
            pend_q    <= 32'd0;
            holdNum_q <= 5'd0;
            holdVal_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            holdNum_q <= holdNum_d;
            holdVal_q <= holdVal_d;
        end
    end

endmodule

// File: tb/tb_wb_hazard_ctrl.sv
// tb_wb_hazard_ctrl
//
// Directed scenarios followed by a randomized run. Expected outputs come from
// a reference model that keeps the scoreboard as an array of flags and the
// write port backlog as a queue of parked ALU results.

module tb_wb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        rstN;
    logic        decValid;
    logic [4:0]  rs1Num, rs2Num, rdNum;
    logic        rs1Used, rs2Used, rdWr, bTaken;
    logic        stall, issue, flushIf;
    logic        aluValid;
    logic [4:0]  aluNum;
    logic [31:0] aluVal;
    logic        aluReady;
    logic        memValid;
    logic [4:0]  memNum;
    logic [31:0] memVal;
    logic        regOp;
    logic [4:0]  wNum;
    logic [31:0] wVal;

    int vectors     = 0;
    int checks      = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]  num;
        logic [31:0] val;
    } wr_t;

    bit          pendM[32];
    wr_t         holdQ[$];
    bit          modelValid = 1'b0;
    bit          expStall, expIssue, expFlush, expAluReady, expRegOp;
    logic [4:0]  expNum;
    logic [31:0] expVal;
    bit          commitFromHold, pushAlu;
    bit          aluHold;

    always #5 clock = ~clock;

    wb_hazard_ctrl dut (
        .i_clk          (clock),
        .i_rst          (rstN),
        .i_dec_valid    (decValid),
        .i_rs1_num      (rs1Num),
        .i_rs2_num      (rs2Num),
        .i_rs1_used     (rs1Used),
        .i_rs2_used     (rs2Used),
        .i_rd_num       (rdNum),
        .i_rd_wr        (rdWr),
        .i_b_taken      (bTaken),
        .o_stall        (stall),
        .o_issue        (issue),
        .o_flush_if     (flushIf),
        .i_alu_wr_valid (aluValid),
        .i_alu_rd_num   (aluNum),
        .i_alu_rd_val   (aluVal),
        .o_alu_ready    (aluReady),
        .i_mem_wr_valid (memValid),
        .i_mem_rd_num   (memNum),
        .i_mem_rd_val   (memVal),
        .o_reg_op       (regOp),
        .o_w_rd_num     (wNum),
        .o_w_rd         (wVal)
    );

    // Single comparison point: counts, and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference prediction of this cycle's outputs from the current inputs.
    task automatic predict();
        wr_t c;
        bit  hz;
        bit  commitValid;
        c              = '0;
        commitValid    = 1'b0;
        commitFromHold = 1'b0;
        pushAlu        = 1'b0;
        expAluReady    = (holdQ.size() == 0);
        hz = decValid && ((rs1Used && pendM[rs1Num]) ||
                          (rs2Used && pendM[rs2Num]) ||
                          (rdWr && pendM[rdNum]));
        expStall = hz || (aluValid && !expAluReady);
        expIssue = decValid && !expStall;
        expFlush = expIssue && bTaken;
        if (memValid) begin
            commitValid = 1'b1;
            c           = {memNum, memVal};
            pushAlu     = aluValid && expAluReady;
        end else if (holdQ.size() != 0) begin
            commitValid    = 1'b1;
            commitFromHold = 1'b1;
            c              = holdQ[0];
        end else if (aluValid) begin
            commitValid = 1'b1;
            c           = {aluNum, aluVal};
        end
        expRegOp = commitValid && (c.num != 5'd0);
        expNum   = c.num;
        expVal   = c.val;
    endtask

    // Advance the model at the clock edge.
    task automatic updateModel();
        if (!rstN) begin
            foreach (pendM[i]) pendM[i] = 1'b0;
            holdQ.delete();
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (expRegOp) pendM[expNum] = 1'b0;
            if (expIssue && rdWr && (rdNum != 5'd0)) pendM[rdNum] = 1'b1;
            if (commitFromHold) void'(holdQ.pop_front());
            if (pushAlu) holdQ.push_back({aluNum, aluVal});
        end
    endtask

    // Sample outputs mid-cycle and compare against the model.
    task automatic applyStimulus();
        @(negedge clock);
        vectors++;
        if (modelValid) begin
            predict();
            checkOutput("stall", stall, expStall);
            checkOutput("issue", issue, expIssue);
            checkOutput("flush_if", flushIf, expFlush);
            checkOutput("alu_ready", aluReady, expAluReady);
            checkOutput("reg_op", regOp, expRegOp);
            if (expRegOp) begin
                checkOutput("w_rd_num", wNum, expNum);
                checkOutput("w_rd", wVal, expVal);
            end
        end
    endtask

    task automatic endCycle();
        @(posedge clock);
        updateModel();
        #1;
    endtask

    task automatic stepCycle();
        applyStimulus();
        endCycle();
    endtask

    task automatic setIdle();
        rstN     = 1'b1;
        decValid = 1'b0;
        rs1Num   = 5'd0;
        rs2Num   = 5'd0;
        rdNum    = 5'd0;
        rs1Used  = 1'b0;
        rs2Used  = 1'b0;
        rdWr     = 1'b0;
        bTaken   = 1'b0;
        aluValid = 1'b0;
        aluNum   = 5'd0;
        aluVal   = 32'd0;
        memValid = 1'b0;
        memNum   = 5'd0;
        memVal   = 32'd0;
    endtask

    initial begin
        // Reset with idle inputs, then check reset values.
        setIdle();
        rstN = 1'b0;
        stepCycle();
        stepCycle();
        rstN = 1'b1;
        applyStimulus();
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_issue", issue, 1'b0);
        checkOutput("rst_flush", flushIf, 1'b0);
        checkOutput("rst_alu_ready", aluReady, 1'b1);
        checkOutput("rst_reg_op", regOp, 1'b0);
        checkOutput("rst_w_rd_num", wNum, 5'd0);
        checkOutput("rst_w_rd", wVal, 32'd0);
        endCycle();

        // RAW: writer of r5, then a reader stalls until r5 commits.
        decValid = 1'b1; rdNum = 5'd5; rdWr = 1'b1;
        stepCycle();
        rdWr = 1'b0; rdNum = 5'd0; rs1Num = 5'd5; rs1Used = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("raw_stall", stall, 1'b1);
            endCycle();
        end
        memValid = 1'b1; memNum = 5'd5; memVal = 32'h0000_00AA;
        applyStimulus();
        checkOutput("raw_commit_stall", stall, 1'b1);
        checkOutput("raw_commit_num", wNum, 5'd5);
        checkOutput("raw_commit_val", wVal, 32'h0000_00AA);
        endCycle();
        memValid = 1'b0;
        applyStimulus();
        checkOutput("raw_issue", issue, 1'b1);
        endCycle();
        setIdle();

        // WAW on r7, cleared by a direct ALU write.
        decValid = 1'b1; rdNum = 5'd7; rdWr = 1'b1;
        stepCycle();
        applyStimulus();
        checkOutput("waw_stall", stall, 1'b1);
        endCycle();
        aluValid = 1'b1; aluNum = 5'd7; aluVal = 32'h77;
        applyStimulus();
        checkOutput("waw_alu_commit", wNum, 5'd7);
        checkOutput("waw_stall_commit", stall, 1'b1);
        endCycle();
        aluValid = 1'b0;
        applyStimulus();
        checkOutput("waw_issue", issue, 1'b1);
        endCycle();
        setIdle();
        memValid = 1'b1; memNum = 5'd7; memVal = 32'h7;
        stepCycle();
        setIdle();

        // x0 as destination never becomes pending.
        decValid = 1'b1; rdNum = 5'd0; rdWr = 1'b1;
        stepCycle();
        rs1Used = 1'b1; rs2Used = 1'b1;
        applyStimulus();
        checkOutput("x0_no_stall", stall, 1'b0);
        checkOutput("x0_issue", issue, 1'b1);
        endCycle();
        setIdle();

        // Write-port collision: load wins, ALU is parked, next ALU waits.
        memValid = 1'b1; memNum = 5'd3; memVal = 32'h11;
        aluValid = 1'b1; aluNum = 5'd4; aluVal = 32'h22;
        applyStimulus();
        checkOutput("col_c0_num", wNum, 5'd3);
        checkOutput("col_c0_val", wVal, 32'h11);
        endCycle();
        memValid = 1'b0;
        aluNum = 5'd6; aluVal = 32'h33;
        applyStimulus();
        checkOutput("col_c1_ready", aluReady, 1'b0);
        checkOutput("col_c1_num", wNum, 5'd4);
        checkOutput("col_c1_val", wVal, 32'h22);
        endCycle();
        applyStimulus();
        checkOutput("col_c2_num", wNum, 5'd6);
        checkOutput("col_c2_val", wVal, 32'h33);
        endCycle();
        setIdle();

        // Branch flush: unstalled branch flushes for one cycle only.
        decValid = 1'b1; bTaken = 1'b1;
        applyStimulus();
        checkOutput("br_flush", flushIf, 1'b1);
        endCycle();
        setIdle();
        applyStimulus();
        checkOutput("br_flush_off", flushIf, 1'b0);
        endCycle();

        // Branch held off while RAW-stalled on r10.
        decValid = 1'b1; rdNum = 5'd10; rdWr = 1'b1;
        stepCycle();
        rdWr = 1'b0; rdNum = 5'd0; rs1Num = 5'd10; rs1Used = 1'b1; bTaken = 1'b1;
        stepCycle();
        memValid = 1'b1; memNum = 5'd10; memVal = 32'hA0;
        applyStimulus();
        checkOutput("br_stalled_flush", flushIf, 1'b0);
        endCycle();
        memValid = 1'b0;
        applyStimulus();
        checkOutput("br_late_flush", flushIf, 1'b1);
        endCycle();
        setIdle();

        // Reset while a result is held and r9 is pending.
        decValid = 1'b1; rdNum = 5'd9; rdWr = 1'b1;
        stepCycle();
        setIdle();
        memValid = 1'b1; memNum = 5'd1; memVal = 32'h1;
        aluValid = 1'b1; aluNum = 5'd2; aluVal = 32'h2;
        stepCycle();
        aluValid = 1'b0;
        rstN = 1'b0;
        stepCycle();
        setIdle();
        applyStimulus();
        checkOutput("mrst_no_held_write", regOp, 1'b0);
        checkOutput("mrst_alu_ready", aluReady, 1'b1);
        endCycle();
        decValid = 1'b1; rs1Num = 5'd9; rs1Used = 1'b1;
        applyStimulus();
        checkOutput("mrst_reader_issue", issue, 1'b1);
        endCycle();
        setIdle();

        // Randomized traffic on a small register window to force interaction.
        aluHold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rstN     = ($urandom_range(0, 99) != 0);
            decValid = ($urandom_range(0, 3) != 0);
            rs1Num   = 5'($urandom_range(0, 7));
            rs2Num   = 5'($urandom_range(0, 7));
            rdNum    = 5'($urandom_range(0, 7));
            rs1Used  = 1'($urandom_range(0, 1));
            rs2Used  = 1'($urandom_range(0, 1));
            rdWr     = 1'($urandom_range(0, 1));
            bTaken   = ($urandom_range(0, 3) == 0);
            if (!aluHold) begin
                aluValid = 1'($urandom_range(0, 1));
                aluNum   = 5'($urandom_range(0, 7));
                aluVal   = $urandom;
            end
            memValid = ($urandom_range(0, 2) == 0);
            memNum   = 5'($urandom_range(0, 7));
            memVal   = $urandom;
            applyStimulus();
            aluHold = aluValid && !expAluReady;
            endCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
